// File: rtl/ext_pkg.sv
// Immediate-extension helpers shared by the pipelined extender, the
// single-cycle extender path and the ALU source mux.
package ext_pkg;

  localparam logic [1:0] EXT_ZERO   = 2'b00;
  localparam logic [1:0] EXT_SIGN   = 2'b01;
  localparam logic [1:0] EXT_UPPER  = 2'b10;
  localparam logic [1:0] EXT_BRANCH = 2'b11;

  // Widest operand the helper handles; callers truncate to their OUT_W.
  localparam int EXT_MAX_W = 64;
  typedef logic [EXT_MAX_W-1:0] ext_word_t;

  // Extend an in_w-bit immediate to out_w bits. Bits above out_w in the
  // result are junk (sign fill) and must be dropped by the caller.
  function automatic ext_word_t ext_imm(input ext_word_t imm, input logic [1:0] mode,
                                        input int in_w, input int out_w);
    ext_word_t mask, sbit, imm_m, sext, res;
    mask  = {EXT_MAX_W{1'b1}} >> (EXT_MAX_W - in_w);
    sbit  = ext_word_t'(1) << (in_w - 1);
    imm_m = imm & mask;
    sext  = ((imm_m & sbit) != '0) ? (imm_m | ~mask) : imm_m;
    case (mode)
      EXT_ZERO:  res = imm_m;
      EXT_SIGN:  res = sext;
      EXT_UPPER: res = imm_m << (out_w - in_w);
      default:   res = sext << 2;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ext_fifo.sv
// Synchronous FIFO holding extended operands + tags. Head is forced to zero
// when empty so downstream never sees stale payload.
module ext_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] rdata_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender: combinational extension on the input side,
// results queued in a small FIFO to ride out execute-stage stalls.
module imm_ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int W = OUT_W + TAG_W;

  logic [OUT_W-1:0] ext_data;
  logic [W-1:0]     head;
  logic             full, empty;

  assign ext_data = OUT_W'(ext_imm(ext_word_t'(in_imm), in_mode, IN_W, OUT_W));

  // in_ready comes only from registered occupancy, never from out_ready.
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign {out_data, out_tag} = head;

  ext_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid & ~full),
    .pop_i   (out_ready & ~empty),
    .wdata_i ({ext_data, in_tag}),
    .full_o  (full),
    .empty_o (empty),
    .rdata_o (head)
  );

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: default-parameter instance A and a narrow/deep
// instance B (IN_W=12, OUT_W=16, DEPTH=4), vector tables plus a scoreboard.
module tb_imm_ext_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [15:0] a_in_imm = '0;
  logic [1:0]  a_in_mode = '0;
  logic [4:0]  a_in_tag = '0, a_out_tag;
  logic [31:0] a_out_data;

  // Instance B: narrow, deeper FIFO
  logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [11:0] b_in_imm = '0;
  logic [1:0]  b_in_mode = '0;
  logic [4:0]  b_in_tag = '0, b_out_tag;
  logic [15:0] b_out_data;

  imm_ext_pipe u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_imm(a_in_imm), .in_mode(a_in_mode), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_tag(a_out_tag)
  );

  imm_ext_pipe #(.IN_W(12), .OUT_W(16), .TAG_W(5), .DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_imm(b_in_imm), .in_mode(b_in_mode), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference extension written straight from the mode definitions.
  function automatic logic [31:0] model_a(input logic [15:0] imm, input logic [1:0] mode);
    case (mode)
      2'b00:   return {16'h0000, imm};
      2'b01:   return {{16{imm[15]}}, imm};
      2'b10:   return {imm, 16'h0000};
      default: return {{14{imm[15]}}, imm, 2'b00};
    endcase
  endfunction

  function automatic logic [15:0] model_b(input logic [11:0] imm, input logic [1:0] mode);
    case (mode)
      2'b00:   return {4'h0, imm};
      2'b01:   return {{4{imm[11]}}, imm};
      2'b10:   return {imm, 4'h0};
      default: return {{2{imm[11]}}, imm, 2'b00};
    endcase
  endfunction

  typedef struct { logic [31:0] d; logic [4:0] t; } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  // Scoreboard A: expected pushed on accepted input, popped on accepted output.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_a_underflow: got tag %0h expected none", a_out_tag);
        end else begin
          exp_t e;
          e = qa.pop_front();
          chk("sb_a_data", 64'(a_out_data), 64'(e.d));
          chk("sb_a_tag", 64'(a_out_tag), 64'(e.t));
        end
      end
      if (a_in_valid && a_in_ready) qa.push_back('{model_a(a_in_imm, a_in_mode), a_in_tag});
    end
  end

  // Scoreboard B
  always @(negedge clk) begin
    if (!rst) begin
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_b_underflow: got tag %0h expected none", b_out_tag);
        end else begin
          exp_t e;
          e = qb.pop_front();
          chk("sb_b_data", 64'(b_out_data), 64'(e.d));
          chk("sb_b_tag", 64'(b_out_tag), 64'(e.t));
        end
      end
      if (b_in_valid && b_in_ready) qb.push_back('{32'(model_b(b_in_imm, b_in_mode)), b_in_tag});
    end
  end

  typedef struct { logic [15:0] imm; logic [1:0] mode; logic [4:0] tag; logic [31:0] exp; } vec_t;
  vec_t va[6];
  vec_t vb[4];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    va[0] = '{16'h8001, 2'b00, 5'd1,  32'h0000_8001};
    va[1] = '{16'h8001, 2'b01, 5'd2,  32'hFFFF_8001};
    va[2] = '{16'h8001, 2'b10, 5'd3,  32'h8001_0000};
    va[3] = '{16'h8001, 2'b11, 5'd4,  32'hFFFE_0004};
    va[4] = '{16'h7FFF, 2'b01, 5'd31, 32'h0000_7FFF};
    va[5] = '{16'h7FFF, 2'b11, 5'd0,  32'h0001_FFFC};
    vb[0] = '{16'h0801, 2'b00, 5'd5,  32'h0000_0801};
    vb[1] = '{16'h0801, 2'b01, 5'd6,  32'h0000_F801};
    vb[2] = '{16'h0801, 2'b10, 5'd7,  32'h0000_8010};
    vb[3] = '{16'h0801, 2'b11, 5'd8,  32'h0000_E004};

    // Reset state, while rst is still high
    #12;
    chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_out_data", 64'(a_out_data), 64'd0);
    chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    rst = 1'b0;

    // Tests 1/2: one push per vector, result one cycle later
    a_out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      a_in_valid = 1; a_in_imm = va[i].imm; a_in_mode = va[i].mode; a_in_tag = va[i].tag;
      tick();
      a_in_valid = 0;
      chk("a_vec_valid", 64'(a_out_valid), 64'd1);
      chk("a_vec_data", 64'(a_out_data), 64'(va[i].exp));
      chk("a_vec_tag", 64'(a_out_tag), 64'(va[i].tag));
    end
    tick();
    chk("a_vec_drained", 64'(a_out_valid), 64'd0);

    // Test 3: backpressure with tags 1,2,3
    a_out_ready = 0; a_in_mode = 2'b01;
    a_in_valid = 1; a_in_tag = 5'd1; a_in_imm = 16'h1111;
    tick();
    chk("a_bp_ready1", 64'(a_in_ready), 64'd1);
    a_in_tag = 5'd2; a_in_imm = 16'h2222;
    tick();
    chk("a_bp_ready2", 64'(a_in_ready), 64'd0);
    a_in_tag = 5'd3; a_in_imm = 16'hA333;
    tick();
    chk("a_bp_full", 64'(a_in_ready), 64'd0);
    chk("a_bp_head_tag", 64'(a_out_tag), 64'd1);
    a_out_ready = 1;
    tick();
    chk("a_bp_ready_after_pop", 64'(a_in_ready), 64'd1);
    tick();
    a_in_valid = 0;
    tick();
    tick();
    chk("a_bp_drained", 64'(a_out_valid), 64'd0);
    chk("a_bp_queue", 64'(qa.size()), 64'd0);

    // Test 4: count held at 1 with simultaneous push/pop for 8 cycles
    a_out_ready = 0;
    a_in_valid = 1; a_in_tag = 5'd10; a_in_imm = 16'($urandom); a_in_mode = 2'($urandom);
    tick();
    a_out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      a_in_tag = 5'(11 + k); a_in_imm = 16'($urandom); a_in_mode = 2'($urandom);
      tick();
      chk("a_ss_valid", 64'(a_out_valid), 64'd1);
      chk("a_ss_ready", 64'(a_in_ready), 64'd1);
    end
    a_in_valid = 0;
    tick();
    chk("a_ss_drained", 64'(a_out_valid), 64'd0);

    // Test 5: async reset with two entries stored
    a_out_ready = 0;
    a_in_valid = 1; a_in_tag = 5'd20; a_in_imm = 16'hBEEF; a_in_mode = 2'b00;
    tick();
    a_in_tag = 5'd21;
    tick();
    a_in_valid = 0;
    chk("a_rst_pre_full", 64'(a_in_ready), 64'd0);
    #2 rst = 1;
    #1;
    chk("a_arst_valid", 64'(a_out_valid), 64'd0);
    chk("a_arst_data", 64'(a_out_data), 64'd0);
    chk("a_arst_tag", 64'(a_out_tag), 64'd0);
    chk("a_arst_ready", 64'(a_in_ready), 64'd1);
    qa.delete();
    qb.delete();
    @(posedge clk); #2 rst = 0;
    tick();
    a_out_ready = 1;
    a_in_valid = 1; a_in_tag = 5'd7; a_in_imm = 16'h0042; a_in_mode = 2'b00;
    tick();
    a_in_valid = 0;
    chk("a_post_rst_valid", 64'(a_out_valid), 64'd1);
    chk("a_post_rst_tag", 64'(a_out_tag), 64'd7);
    chk("a_post_rst_data", 64'(a_out_data), 64'h42);
    tick();
    chk("a_post_rst_alone", 64'(a_out_valid), 64'd0);

    // Test 6: instance B vectors
    b_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      b_in_valid = 1; b_in_imm = vb[i].imm[11:0]; b_in_mode = vb[i].mode; b_in_tag = vb[i].tag;
      tick();
      b_in_valid = 0;
      chk("b_vec_valid", 64'(b_out_valid), 64'd1);
      chk("b_vec_data", 64'(b_out_data), 64'(vb[i].exp));
      chk("b_vec_tag", 64'(b_out_tag), 64'(vb[i].tag));
    end
    tick();

    // B backpressure: in_ready drops only after four stalled pushes
    b_out_ready = 0; b_in_mode = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) chk("b_bp_ready", 64'(b_in_ready), 64'((k - 1) < 4));
      b_in_valid = 1; b_in_tag = 5'(k); b_in_imm = 12'(k * 300);
      tick();
    end
    chk("b_bp_full", 64'(b_in_ready), 64'd0);
    chk("b_bp_head_tag", 64'(b_out_tag), 64'd1);
    b_out_ready = 1;
    tick();
    chk("b_bp_ready_after_pop", 64'(b_in_ready), 64'd1);
    tick();
    b_in_valid = 0;
    repeat (5) tick();
    chk("b_bp_drained", 64'(b_out_valid), 64'd0);

    // B streaming at count=1, wrapping the 4-entry pointers twice
    b_out_ready = 0;
    b_in_valid = 1; b_in_tag = 5'd9; b_in_imm = 12'($urandom); b_in_mode = 2'($urandom);
    tick();
    b_out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      b_in_tag = 5'(12 + k); b_in_imm = 12'($urandom); b_in_mode = 2'($urandom);
      tick();
      chk("b_ss_valid", 64'(b_out_valid), 64'd1);
    end
    b_in_valid = 0;
    tick();
    chk("b_ss_drained", 64'(b_out_valid), 64'd0);

    tick();
    chk("sb_a_empty_end", 64'(qa.size()), 64'd0);
    chk("sb_b_empty_end", 64'(qb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
